// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//   Shared definitions for the two-requester SRAM arbiter with array
//   zeroing. Contains:
//     - state_e                 : controller state (ST_INIT zeroing, ST_RUN arbitration)
//     - DEF_BITS                : default data word width
//     - DEF_WORD_DEPTH          : default number of RAM words
//     - DEF_ADDR_WIDTH          : default address width (clog2 of depth)
//     - mask_merge()            : bit-masked write merge, as the macro applies it
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_BITS       = 32'd64;
  localparam int unsigned DEF_WORD_DEPTH = 32'd512;
  localparam int unsigned DEF_ADDR_WIDTH = 32'd9;

  // Merge new data into an old word under a per-bit write mask
  // (mask bit 1 = take the new bit). Sized to the default word width.
  function automatic logic [DEF_BITS-1:0] mask_merge(
    input logic [DEF_BITS-1:0] old_word,
    input logic [DEF_BITS-1:0] new_word,
    input logic [DEF_BITS-1:0] mask
  );
    mask_merge = (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage : sram_arb_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. Grants at most one requester per cycle.
//   When both request, the pointer decides; after any grant the pointer
//   passes priority to the other requester. A lone requester is granted
//   every cycle regardless of the pointer.
//
//   Ports:
//     clk_i   : clock, all state on posedge
//     rst_i   : synchronous active-high reset (pointer favours requester 0)
//     en_i    : arbitration enable; no grant is issued while low
//     req_i   : per-requester request
//     gnt_o   : one-hot (or zero) grant, combinational from req_i/pointer
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic ptr_q;
  logic ptr_d;
  logic [1:0] gnt_s;

  // Grant selection from the request vector and the tie-break pointer
  always_comb begin
    gnt_s = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = ptr_q ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Next pointer: after a grant, priority moves to the other requester
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_s[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_s[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_s;

endmodule : rr_arb2

// File: rtl/sram_arb2_init.sv
// ---------------------------------------------------------------------------
// sram_arb2_init
//   Front end for a single-port SRAM macro shared by two requesters.
//   After reset (or a clear request) the whole array is zeroed, one word per
//   cycle; afterwards the two requesters are arbitrated round-robin and
//   their read/write commands are forwarded to the macro in the grant cycle.
//   Read data returns one cycle later straight from the macro output.
//
//   Ports:
//     clk            : clock, all logic on posedge
//     rst            : synchronous active-high reset
//     req_valid[1:0] : per-requester command valid
//     req_ready[1:0] : per-requester accept (combinational, at most one high)
//     req_we[1:0]    : per-requester write enable (0 = read)
//     req_addr       : requester i address in slice i
//     req_wd         : requester i write data in slice i
//     req_mask       : requester i per-bit write mask in slice i
//     rsp_valid[1:0] : read data valid, one cycle after a read accept
//     rsp_rdata      : shared read data (macro output pass-through)
//     clear_req      : request full-array zeroing (honoured only in RUN)
//     init_done      : array zeroed and requests being served
//     ram_*_in       : macro command port (all zero when idle)
//     ram_rd_out     : macro read data
// ---------------------------------------------------------------------------
module sram_arb2_init
  import sram_arb_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*BITS-1:0]       req_wd,
  input  logic [2*BITS-1:0]       req_mask,
  output logic [1:0]              rsp_valid,
  output logic [BITS-1:0]         rsp_rdata,
  input  logic                    clear_req,
  output logic                    init_done,
  output logic                    ram_ce_in,
  output logic                    ram_we_in,
  output logic [ADDR_WIDTH-1:0]   ram_addr_in,
  output logic [BITS-1:0]         ram_wd_in,
  output logic [BITS-1:0]         ram_w_mask_in,
  input  logic [BITS-1:0]         ram_rd_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   cnt_d;
  logic                    init_done_q;
  logic [1:0]              rsp_valid_q;
  logic [1:0]              rsp_valid_d;

  logic                    arb_en_s;
  logic [1:0]              gnt_s;
  logic                    sel_s;
  logic                    xfer_s;

  // Arbitration runs only in RUN and not in a clear cycle; rst also blocks
  // grants so the pointer and response state stay clean during reset.
  assign arb_en_s = (!rst) && (state_q == ST_RUN) && (!clear_req);

  rr_arb2 u_rr_arb2 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (arb_en_s),
    .req_i (req_valid),
    .gnt_o (gnt_s)
  );

  assign xfer_s = gnt_s[0] | gnt_s[1];
  assign sel_s  = gnt_s[1];

  // Zeroing address counter increment
  always_comb begin
    cnt_d = cnt_q + ADDR_WIDTH'(1);
  end

  // Read responses: a read accept this cycle produces a valid next cycle
  always_comb begin
    rsp_valid_d = 2'b00;
    if (xfer_s) begin
      rsp_valid_d = gnt_s & ~req_we;
    end else begin
      rsp_valid_d = 2'b00;
    end
  end

  // Macro command port: zeroing writes in INIT, granted command in RUN,
  // all-zero otherwise so the macro never sees X on an idle cycle.
  always_comb begin
    ram_ce_in     = 1'b0;
    ram_we_in     = 1'b0;
    ram_addr_in   = '0;
    ram_wd_in     = '0;
    ram_w_mask_in = '0;
    if (rst) begin
      ram_ce_in     = 1'b0;
    end else if (state_q == ST_INIT) begin
      ram_ce_in     = 1'b1;
      ram_we_in     = 1'b1;
      ram_addr_in   = cnt_q;
      ram_wd_in     = '0;
      ram_w_mask_in = '1;
    end else if (xfer_s) begin
      ram_ce_in     = 1'b1;
      ram_we_in     = sel_s ? req_we[1] : req_we[0];
      ram_addr_in   = sel_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : req_addr[ADDR_WIDTH-1:0];
      ram_wd_in     = sel_s ? req_wd[2*BITS-1:BITS] : req_wd[BITS-1:0];
      ram_w_mask_in = sel_s ? req_mask[2*BITS-1:BITS] : req_mask[BITS-1:0];
    end else begin
      ram_ce_in     = 1'b0;
    end
  end

  // Controller FSM: zeroing sweep, run mode, clear handling, responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      case (state_q)
        ST_INIT: begin
          // clear_req is deliberately not looked at here: a sweep in
          // progress is never restarted by it.
          if (cnt_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q       <= cnt_d;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
          end else begin
            state_q     <= ST_RUN;
          end
        end
        default: begin
          state_q     <= ST_INIT;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = gnt_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = ram_rd_out;
  assign init_done = init_done_q;

endmodule : sram_arb2_init

// File: tb/tb_sram_arb2_init.sv
// ---------------------------------------------------------------------------
// tb_sram_arb2_init
//   Directed bench for sram_arb2_init with a behavioural single-port SRAM
//   (synchronous read, bit-masked write) attached to the macro port.
// ---------------------------------------------------------------------------
module tb_sram_arb2_init;

  localparam int BITS = 64;
  localparam int WD   = 512;
  localparam int AW   = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*BITS-1:0] req_wd;
  logic [2*BITS-1:0] req_mask;
  logic [1:0]      rsp_valid;
  logic [BITS-1:0] rsp_rdata;
  logic            clear_req;
  logic            init_done;
  logic            ram_ce_in;
  logic            ram_we_in;
  logic [AW-1:0]   ram_addr_in;
  logic [BITS-1:0] ram_wd_in;
  logic [BITS-1:0] ram_w_mask_in;
  logic [BITS-1:0] ram_rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BITS-1:0] mem [0:WD-1];

  always #5 clk = ~clk;

  sram_arb2_init #(.BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wd        (req_wd),
    .req_mask      (req_mask),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .clear_req     (clear_req),
    .init_done     (init_done),
    .ram_ce_in     (ram_ce_in),
    .ram_we_in     (ram_we_in),
    .ram_addr_in   (ram_addr_in),
    .ram_wd_in     (ram_wd_in),
    .ram_w_mask_in (ram_w_mask_in),
    .ram_rd_out    (ram_rd_out)
  );

  // Single-port SRAM macro model
  always @(posedge clk) begin
    if (ram_ce_in === 1'b1) begin
      if (ram_we_in === 1'b1)
        mem[ram_addr_in] <= (mem[ram_addr_in] & ~ram_w_mask_in) | (ram_wd_in & ram_w_mask_in);
      else
        ram_rd_out <= mem[ram_addr_in];
    end
  end

  task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [BITS-1:0] d0, input logic [BITS-1:0] d1,
                         input logic [BITS-1:0] m0, input logic [BITS-1:0] m1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wd    = {d1, d0};
    req_mask  = {m1, m0};
  endtask

  // Idle with junk payload so leaking fields onto the RAM port would show
  task automatic set_idle();
    set_req(2'b00, 2'b11, 9'h1AB, 9'h0F3, 64'hA5A5_5A5A_0123_4567,
            64'h89AB_CDEF_FEDC_BA98, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
  endtask

  task automatic test_reset_init();
    rst = 1'b1;
    clear_req = 1'b0;
    set_req(2'b11, 2'b00, 9'd1, 9'd2, 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    if (init_done !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || ram_ce_in !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state init_done=%b rsp_valid=%b req_ready=%b ce=%b exp 0/00/00/0",
               init_done, rsp_valid, req_ready, ram_ce_in);
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < WD; i++) begin
      #1;
      if (ram_ce_in !== 1'b1 || ram_we_in !== 1'b1 || ram_addr_in !== AW'(i) ||
          ram_wd_in !== 64'h0 || ram_w_mask_in !== {BITS{1'b1}} || init_done !== 1'b0) begin
        n_bad++;
        $display("FAIL init_write[%0d] ce=%b we=%b addr=%0d wd=%h mask=%h done=%b exp 1 1 %0d 0 ones 0",
                 i, ram_ce_in, ram_we_in, ram_addr_in, ram_wd_in, ram_w_mask_in, init_done, i);
      end
      n_cmp++;
      @(negedge clk);
    end
    #1;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL init_done_rise got %b exp 1", init_done);
    end
    n_cmp++;
    if (ram_ce_in !== 1'b0 || ram_we_in !== 1'b0 || ram_addr_in !== 9'd0 ||
        ram_wd_in !== 64'd0 || ram_w_mask_in !== 64'd0) begin
      n_bad++;
      $display("FAIL idle_port ce=%b we=%b addr=%h wd=%h mask=%h exp all 0",
               ram_ce_in, ram_we_in, ram_addr_in, ram_wd_in, ram_w_mask_in);
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    // Seed addr 1 (requester 0) and addr 2 (requester 1); pointer ends at 0
    set_req(2'b01, 2'b01, 9'd1, 9'd0, 64'h1111_1111_1111_1111, 64'd0, {BITS{1'b1}}, 64'd0);
    #1;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL seed0_ready got %b exp 01", req_ready);
    end
    n_cmp++;
    @(negedge clk);
    set_req(2'b10, 2'b10, 9'd0, 9'd2, 64'd0, 64'h2222_2222_2222_2222, 64'd0, {BITS{1'b1}});
    #1;
    if (req_ready !== 2'b10) begin
      n_bad++;
      $display("FAIL seed1_ready got %b exp 10", req_ready);
    end
    n_cmp++;
    @(negedge clk);
    set_req(2'b11, 2'b00, 9'd1, 9'd2, 64'd0, 64'd0, 64'd0, 64'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
          ram_addr_in !== ((k % 2 == 0) ? 9'd1 : 9'd2) || ram_ce_in !== 1'b1) begin
        n_bad++;
        $display("FAIL alt_grant[%0d] ready=%b addr=%0d ce=%b exp %s", k, req_ready,
                 ram_addr_in, ram_ce_in, (k % 2 == 0) ? "01 1 1" : "10 2 1");
      end
      n_cmp++;
      if (k == 0) begin
        if (rsp_valid !== 2'b00) begin
          n_bad++;
          $display("FAIL alt_rsp[0] got %b exp 00", rsp_valid);
        end
        n_cmp++;
      end else begin
        if (rsp_valid !== ((k % 2 == 1) ? 2'b01 : 2'b10) ||
            rsp_rdata !== ((k % 2 == 1) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222)) begin
          n_bad++;
          $display("FAIL alt_rsp[%0d] valid=%b data=%h exp %s", k, rsp_valid, rsp_rdata,
                   (k % 2 == 1) ? "01 1111..." : "10 2222...");
        end
        n_cmp++;
      end
      @(negedge clk);
    end
    set_idle();
    #1;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 64'h2222_2222_2222_2222) begin
      n_bad++;
      $display("FAIL alt_rsp[4] valid=%b data=%h exp 10 2222222222222222", rsp_valid, rsp_rdata);
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    set_req(2'b01, 2'b01, 9'd5, 9'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, {BITS{1'b1}}, 64'd0);
    #1;
    if (req_ready !== 2'b01 || ram_ce_in !== 1'b1 || ram_we_in !== 1'b1 || ram_addr_in !== 9'd5 ||
        ram_wd_in !== 64'hDEAD_BEEF_CAFE_F00D || ram_w_mask_in !== {BITS{1'b1}}) begin
      n_bad++;
      $display("FAIL wr_cmd ready=%b ce=%b we=%b addr=%0d wd=%h mask=%h exp 01 1 1 5 deadbeefcafef00d ones",
               req_ready, ram_ce_in, ram_we_in, ram_addr_in, ram_wd_in, ram_w_mask_in);
    end
    n_cmp++;
    @(negedge clk);
    set_req(2'b01, 2'b00, 9'd5, 9'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    #1;
    if (rsp_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL wr_no_rsp got %b exp 00", rsp_valid);
    end
    n_cmp++;
    if (req_ready !== 2'b01 || ram_we_in !== 1'b0 || ram_addr_in !== 9'd5) begin
      n_bad++;
      $display("FAIL rd_cmd ready=%b we=%b addr=%0d exp 01 0 5", req_ready, ram_we_in, ram_addr_in);
    end
    n_cmp++;
    @(negedge clk);
    set_idle();
    #1;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
      n_bad++;
      $display("FAIL rd_rsp valid=%b data=%h exp 01 deadbeefcafef00d", rsp_valid, rsp_rdata);
    end
    n_cmp++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_rsp_pulse got %b exp 00", rsp_valid);
    end
    n_cmp++;
  endtask

  task automatic test_mask();
    set_req(2'b10, 2'b10, 9'd0, 9'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0000_0000_FFFF_FFFF);
    #1;
    if (req_ready !== 2'b10 || ram_w_mask_in !== 64'h0000_0000_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL mask_cmd ready=%b mask=%h exp 10 00000000ffffffff", req_ready, ram_w_mask_in);
    end
    n_cmp++;
    @(negedge clk);
    set_req(2'b10, 2'b00, 9'd0, 9'd7, 64'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    set_idle();
    #1;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 64'h0000_0000_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL mask_rsp valid=%b data=%h exp 10 00000000ffffffff", rsp_valid, rsp_rdata);
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_clear();
    set_req(2'b11, 2'b00, 9'd1, 9'd2, 64'd0, 64'd0, 64'd0, 64'd0);
    clear_req = 1'b1;
    #1;
    if (req_ready !== 2'b00 || ram_ce_in !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_no_grant ready=%b ce=%b exp 00 0", req_ready, ram_ce_in);
    end
    n_cmp++;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < WD; i++) begin
      clear_req = (i == 100) ? 1'b1 : 1'b0;
      #1;
      if (ram_ce_in !== 1'b1 || ram_we_in !== 1'b1 || ram_addr_in !== AW'(i) ||
          ram_wd_in !== 64'h0 || req_ready !== 2'b00 || rsp_valid !== 2'b00 || init_done !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_zero[%0d] ce=%b we=%b addr=%0d wd=%h ready=%b rsp=%b done=%b exp 1 1 %0d 0 00 00 0",
                 i, ram_ce_in, ram_we_in, ram_addr_in, ram_wd_in, req_ready, rsp_valid, init_done, i);
      end
      n_cmp++;
      @(negedge clk);
    end
    clear_req = 1'b0;
    set_idle();
    #1;
    if (init_done !== 1'b1 || ram_ce_in !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_done done=%b ce=%b exp 1 0", init_done, ram_ce_in);
    end
    n_cmp++;
    @(negedge clk);
    set_req(2'b01, 2'b00, 9'd5, 9'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    #1;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL clear_rd_ready got %b exp 01", req_ready);
    end
    n_cmp++;
    @(negedge clk);
    set_idle();
    #1;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 64'd0) begin
      n_bad++;
      $display("FAIL clear_rd_zero valid=%b data=%h exp 01 0", rsp_valid, rsp_rdata);
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_rst_mid_init();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    if (ram_addr_in !== 9'd200 || ram_ce_in !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_init_addr addr=%0d ce=%b exp 200 1", ram_addr_in, ram_ce_in);
    end
    n_cmp++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WD; i++) begin
      #1;
      if (ram_ce_in !== 1'b1 || ram_addr_in !== AW'(i) || init_done !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_rezero[%0d] ce=%b addr=%0d done=%b exp 1 %0d 0",
                 i, ram_ce_in, ram_addr_in, init_done, i);
      end
      n_cmp++;
      @(negedge clk);
    end
    #1;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_done got %b exp 1", init_done);
    end
    n_cmp++;
    @(negedge clk);
  endtask

  initial begin
    test_reset_init();
    test_alternate();
    test_write_read();
    test_mask();
    test_clear();
    test_rst_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_sram_arb2_init

// File: doc/sram_arb2_init.md
SRAM_ARB2_INIT -- requirements
Module: sram_arb2_init

Interface
REQ-001 SHALL have parameter BITS, default 64, data word width.
REQ-002 SHALL have parameter WORD_DEPTH, default 512, number of RAM words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, address width (clog2 WORD_DEPTH).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 2, per-requester request valid.
REQ-007 SHALL have port req_ready, output, 2, per-requester grant/accept.
REQ-008 SHALL have port req_we, input, 2, per-requester write enable (0 = read).
REQ-009 SHALL have port req_addr, input, 2*ADDR_WIDTH, requester i in slice i.
REQ-010 SHALL have port req_wd, input, 2*BITS, write data per requester.
REQ-011 SHALL have port req_mask, input, 2*BITS, bit write mask per requester.
REQ-012 SHALL have port rsp_valid, output, 2, read-data-valid per requester.
REQ-013 SHALL have port rsp_rdata, output, BITS, shared read data.
REQ-014 SHALL have port clear_req, input, 1, request full-array zeroing.
REQ-015 SHALL have port init_done, output, 1, high when the array is zeroed and requests are served.
REQ-016 SHALL have ports ram_ce_in, ram_we_in (1), ram_addr_in (ADDR_WIDTH), ram_wd_in and ram_w_mask_in (BITS), all outputs, and ram_rd_out (BITS), input, connecting the single-port macro.

Function
REQ-017 SHALL implement two states: INIT (zeroing) and RUN (arbitration).
REQ-018 INIT SHALL issue one write per cycle (ce=1, we=1, wd=0, mask all-ones) at addr = 9-bit counter, counting 0..WORD_DEPTH-1.
REQ-019 After the write to WORD_DEPTH-1 the FSM SHALL enter RUN; init_done SHALL rise the following cycle, 512 cycles after INIT entry.
REQ-020 In INIT, req_ready SHALL be 0 and rsp_valid SHALL be 0, except a read accepted in the last RUN cycle, which completes normally.
REQ-021 In RUN, at most one req_ready bit SHALL be high per cycle; req_ready[i] is combinational from req_valid and the round-robin pointer.
REQ-022 Arbitration SHALL be round-robin: after a grant to i, priority passes to the other requester; a lone valid requester is granted every cycle.
REQ-023 A transfer occurs when req_valid[i] && req_ready[i]; the RAM port SHALL then carry requester i's we/addr/wd/mask with ce=1 in that same cycle.
REQ-024 With no transfer, ram_ce_in, ram_we_in, ram_addr_in, ram_wd_in and ram_w_mask_in SHALL all be 0 (never X).
REQ-025 For a read transfer, rsp_valid[i] SHALL pulse exactly one cycle later, with rsp_rdata = ram_rd_out (pass-through); writes produce no response.
REQ-026 rsp_rdata SHALL be don't-care when rsp_valid is 0; no response backpressure exists.
REQ-027 clear_req high in RUN SHALL suppress all grants that cycle and move the FSM to INIT with the counter at 0.
REQ-028 clear_req SHALL be ignored in INIT; zeroing is not restarted.
REQ-029 Requesters SHALL hold valid, addr and data stable until accepted; the block does not check this.

Reset
REQ-030 rst SHALL put the FSM in INIT with the counter at 0 and the RR pointer favouring requester 0; init_done, rsp_valid and req_ready are 0.
REQ-031 rst asserted mid-INIT or mid-RUN SHALL restart zeroing from address 0; in-flight read responses are dropped.

Structure
REQ-032 A shared package sram_arb_pkg SHALL hold the FSM state enum (INIT, RUN) and the default BITS/WORD_DEPTH/ADDR_WIDTH constants.
REQ-033 A sub-module rr_arb2 SHALL implement the 2-way round-robin grant and pointer update.

Verification
REQ-034 Reset, then idle: exactly 512 writes at addr 0..511 with wd=0 and mask all-ones; init_done rises at cycle 513; ram_ce_in is 0 afterwards.
REQ-035 Requester 0 writes 0xDEADBEEF_CAFEF00D to addr 5 with full mask, then reads addr 5: rsp_valid[0] one cycle after the read grant, with the same data.
REQ-036 Both requesters hold valid with reads to addr 1 and addr 2 for 4 cycles: grants alternate 0,1,0,1 and each rsp_valid follows its grant by one cycle.
REQ-037 Write 0xFFFF_FFFF_FFFF_FFFF with mask 0x0000_0000_FFFF_FFFF to a zeroed word: read returns 0x0000_0000_FFFF_FFFF.
REQ-038 clear_req in RUN while both requesters are valid: no grant that cycle, then 512 zeroing writes; a read of the earlier-written addr 5 returns 0.
REQ-039 rst asserted at INIT counter 200: the next write is to addr 0, and init_done rises 513 cycles after rst deasserts.
